// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
// Tuse/Tnew are "cycles until needed / cycles until ready"; TUSE_NONE marks an unused operand.
package pipe_ctrl_pkg;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int MD_CNT_W     = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [4:0] reg_idx_t;

  // A source operand must wait when a producer ahead of it will not have its result in time.
  function automatic logic src_hazard(
    input reg_idx_t   src,
    input logic [1:0] tuse,
    input reg_idx_t   e_wa,
    input logic [1:0] e_tnew,
    input reg_idx_t   m_wa,
    input logic [1:0] m_tnew
  );
    logic w_e_hit;
    logic w_m_hit;
    w_e_hit = (src == e_wa) && (tuse < e_tnew);
    w_m_hit = (src == m_wa) && (tuse < m_tnew);
    return (tuse != TUSE_NONE) && (src != REG_ZERO) && (w_e_hit || w_m_hit);
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Occupancy counter for the multi-cycle mult/div unit.
// A start suppressed by intexc does not load; an operation already running keeps counting.
module md_busy_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                intexc,
  input  logic                e_md_start,
  input  logic                e_md_div,
  output logic [MD_CNT_W-1:0] md_cnt,
  output logic                md_busy
);

  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_load_val;

  assign w_load_val = e_md_div ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);

  // Load on a legal start, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (e_md_start && !intexc) begin
      r_md_cnt <= w_load_val;
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - MD_CNT_W'(1);
    end else begin
      r_md_cnt <= r_md_cnt;
    end
  end

  assign md_cnt  = r_md_cnt;
  assign md_busy = e_md_start || (r_md_cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: Tuse/Tnew register hazards, mult/div occupancy, flush folding.
// Define PIPE_HAZARD_MD_EN to build the mult/div busy tracker; otherwise md_cnt/md_busy are tied to 0.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                intexc,
  input  logic [4:0]          d_rs,
  input  logic [4:0]          d_rt,
  input  logic [1:0]          d_tuse_rs,
  input  logic [1:0]          d_tuse_rt,
  input  logic [4:0]          e_wa,
  input  logic [1:0]          e_tnew,
  input  logic [4:0]          m_wa,
  input  logic [1:0]          m_tnew,
  input  logic                d_md,
  input  logic                e_md_start,
  input  logic                e_md_div,
  input  logic                d_clr_req,
  output logic                stall,
  output logic                flush_e,
  output logic                dclr,
  output logic                md_busy,
  output logic [MD_CNT_W-1:0] md_cnt
);

  logic w_hz_rs;
  logic w_hz_rt;
  logic w_md_hazard;
  logic w_stall;

  assign w_hz_rs = src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
  assign w_hz_rt = src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);

`ifdef PIPE_HAZARD_MD_EN
  md_busy_tracker #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_tracker (
    .clk        (clk),
    .reset      (reset),
    .intexc     (intexc),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .md_cnt     (md_cnt),
    .md_busy    (md_busy)
  );

  assign w_md_hazard = d_md && md_busy;
`else
  logic w_unused_md;

  assign w_unused_md = ^{d_md, e_md_start, e_md_div, clk};
  assign md_cnt      = '0;
  assign md_busy     = 1'b0;
  assign w_md_hazard = 1'b0;
`endif

  // reset and intexc override the stall; a stall in turn blocks the delay-slot annul.
  assign w_stall = (w_hz_rs || w_hz_rt || w_md_hazard) && !intexc && !reset;
  assign stall   = w_stall;
  assign flush_e = w_stall || intexc || reset;
  assign dclr    = intexc || reset || (d_clr_req && !w_stall);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan scenarios followed by random traffic.
// The mult/div model tracks the cycle at which the unit becomes free.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset, intexc, d_md, e_md_start, e_md_div, d_clr_req;
  logic [4:0] d_rs, d_rt, e_wa, m_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       stall, flush_e, dclr, md_busy;
  logic [3:0] md_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk(clk), .reset(reset), .intexc(intexc),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
    .d_md(d_md), .e_md_start(e_md_start), .e_md_div(e_md_div), .d_clr_req(d_clr_req),
    .stall(stall), .flush_e(flush_e), .dclr(dclr), .md_busy(md_busy), .md_cnt(md_cnt)
  );

  typedef struct {
    logic [7:0] exp;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   now;
  int   free_cyc;
  int   n_checks = 0;
  int   n_pass   = 0;

  // An operand waits if it is used and some producer ahead will be ready later than needed.
  function automatic bit must_wait(input logic [4:0] src, input logic [1:0] tuse);
    int dest[2];
    int ready_in[2];
    dest[0] = int'(e_wa);  ready_in[0] = int'(e_tnew);
    dest[1] = int'(m_wa);  ready_in[1] = int'(m_tnew);
    if (tuse == 2'd3 || src == 5'd0) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (int'(src) == dest[i] && int'(tuse) < ready_in[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    reset = 1'b0; intexc = 1'b0; d_md = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
    d_clr_req = 1'b0; d_rs = 5'd0; d_rt = 5'd0; e_wa = 5'd0; m_wa = 5'd0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; e_tnew = 2'd0; m_tnew = 2'd0;
  endtask

  // Push the expected outputs for the current inputs, then advance the model by one edge.
  task automatic step();
    exp_t e;
    int   left;
    bit   busy, stl, fl, dc;
    left = free_cyc - now;
    if (left < 0) left = 0;
    if (!MD_EN) left = 0;
    busy = MD_EN && (e_md_start || left > 0);
    stl  = (must_wait(d_rs, d_tuse_rs) || must_wait(d_rt, d_tuse_rt) || (d_md && busy))
           && !intexc && !reset;
    fl   = stl || intexc || reset;
    dc   = intexc || reset || (d_clr_req && !stl);
    e.exp = {stl, fl, dc, busy, 4'(left)};
    e.cyc = now;
    q.push_back(e);
    @(posedge clk);
    if (reset) free_cyc = now + 1;
    else if (MD_EN && e_md_start && !intexc) free_cyc = now + 1 + (e_md_div ? DIV_N : MULT_N);
    now++;
    #1;
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e   = q.pop_front();
      got = {stall, flush_e, dclr, md_busy, md_cnt};
      n_checks++;
      if (got === e.exp) n_pass++;
      else $display("FAIL outputs cyc=%0d got{stall,flush_e,dclr,busy,cnt}=%b want=%b",
                    e.cyc, got, e.exp);
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    now = 0; free_cyc = 0;

    // Reset: stall forced low even with a hazard present.
    step();
    e_wa = 5'd2; e_tnew = 2'd2; d_rs = 5'd2; d_tuse_rs = 2'd1;
    step();
    // Load-use, then lw moves to M.
    reset = 1'b0;
    step();
    e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd2; m_tnew = 2'd1;
    step();
    // Register $0.
    idle(); e_wa = 5'd0; e_tnew = 2'd2; d_rs = 5'd0; d_tuse_rs = 2'd0;
    step();
    // Unused operand.
    idle(); d_rt = 5'd5; e_wa = 5'd5; e_tnew = 2'd2; d_tuse_rt = 2'd3;
    step();
    // Mult then mfhi held in D.
    idle(); d_md = 1'b1; e_md_start = 1'b1;
    step();
    e_md_start = 1'b0;
    repeat (7) step();
    // Div then exception at t+3.
    idle(); e_md_start = 1'b1; e_md_div = 1'b1; d_md = 1'b1;
    step();
    e_md_start = 1'b0;
    repeat (2) step();
    intexc = 1'b1;
    step();
    intexc = 1'b0;
    repeat (9) step();
    // Start suppressed by intexc.
    idle(); e_md_start = 1'b1; intexc = 1'b1;
    step();
    idle();
    repeat (2) step();
    // Reset mid-divide.
    idle(); e_md_start = 1'b1; e_md_div = 1'b1;
    step();
    e_md_start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (2) step();
    // Delay-slot annul with and without a stall.
    idle(); d_clr_req = 1'b1; e_wa = 5'd3; e_tnew = 2'd2; d_rs = 5'd3; d_tuse_rs = 2'd0;
    step();
    d_rs = 5'd4;
    step();

    // Random traffic over a small register set to provoke matches.
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      intexc     = ($urandom_range(0, 19) == 0);
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      e_wa       = 5'($urandom_range(0, 3));
      m_wa       = 5'($urandom_range(0, 3));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      e_tnew     = 2'($urandom_range(0, 2));
      m_tnew     = 2'($urandom_range(0, 1));
      d_md       = ($urandom_range(0, 2) == 0);
      e_md_start = ($urandom_range(0, 11) == 0);
      e_md_div   = 1'($urandom_range(0, 1));
      d_clr_req  = 1'($urandom_range(0, 1));
      step();
    end
    idle();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. Compares D-stage source-register demand (Tuse) against E/M-stage result readiness (Tnew) and generates the stall and clear controls that drive the F PC enable, the D pipeline register, and the E pipeline register. Also tracks the multi-cycle mult/div unit so that HI/LO-touching instructions wait in D, and folds the exception/interrupt flush and the delay-slot annul request into one consistent set of controls.

## Interface
Parameters:
- MULT_CYC, 5: cycles the mult unit stays busy after the start cycle.
- DIV_CYC, 10: cycles the div unit stays busy after the start cycle.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- intexc  in  1  exception/interrupt taken this cycle; flush request.
- d_rs, d_rt  in  5 each  D-stage source register numbers.
- d_tuse_rs, d_tuse_rt  in  2 each  cycles until the operand is needed: 0, 1 or 2; 3 means unused.
- e_wa  in  5  E-stage destination register.
- e_tnew  in  2  cycles until the E result is available: 0, 1 or 2.
- m_wa  in  5  M-stage destination register.
- m_tnew  in  2  cycles until the M result is available: 0 or 1.
- d_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_md_start  in  1  E instruction starts a mult or div this cycle.
- e_md_div  in  1  qualifies e_md_start: 1 means div, 0 means mult.
- d_clr_req  in  1  annul the instruction entering D (delay-slot annul).
- stall  out  1  hold PC and the D register.
- flush_e  out  1  load a bubble into the E register.
- dclr  out  1  clear the D register.
- md_busy  out  1  mult/div unit occupied.
- md_cnt  out  4  remaining busy cycles.

## Operation
- Register hazard on rs: `d_tuse_rs != 3` and `d_rs != 0` and either
  - `d_rs == e_wa` and `d_tuse_rs < e_tnew`, or
  - `d_rs == m_wa` and `d_tuse_rs < m_tnew`.
- Register hazard on rt: same rule using the rt fields.
- md_hazard = d_md & md_busy.
- Base stall condition: rs hazard | rt hazard | md_hazard.
- stall = (base condition) & ~intexc & ~reset.
- flush_e = stall | intexc | reset.
- dclr = intexc | reset | (d_clr_req & ~stall).
- Busy tracker:
  - md_busy = e_md_start | (md_cnt != 0).
  - When `e_md_start & ~intexc`, md_cnt loads MULT_CYC or DIV_CYC.
  - Otherwise, when `md_cnt != 0`, md_cnt decrements by 1.
  - md_cnt saturates at 0.
  - A start issued while the unit is busy reloads md_cnt; this case cannot occur in legal operation, because D stalls first.
- intexc:
  - A start in the same cycle is suppressed: no load.
  - An operation already in flight keeps counting down.
- reset: md_cnt = 0 and md_busy = 0 on the next edge, including reset in the middle of a divide.

## Timing
- stall, flush_e and dclr are combinational within the same cycle; there is no registered latency.
- md_cnt is the only state. Its update takes effect at the next clk edge.
- Mult started in cycle t:
  - md_cnt = 5 at t+1 and reaches 0 at t+6.
  - md_busy is high from t to t+5.
  - An mfhi held in D stalls for cycles t..t+5 and advances at t+6.
- Div started in cycle t: md_busy is high from t to t+10.
- Reset values: md_cnt = 0, md_busy = 0. While reset is high: stall = 0, flush_e = 1, dclr = 1.
- Precedence: reset > intexc > stall > d_clr_req.

## Configuration
- PIPE_HAZARD_MD_EN defined: the busy tracker is instantiated and md_hazard is active.
- PIPE_HAZARD_MD_EN undefined:
  - No tracker is built; md_cnt is tied to 0 and md_busy is tied to 0.
  - d_md, e_md_start and e_md_div are ignored.
  - Only register hazards stall.

## Structure
- Package pipe_ctrl_pkg holds:
  - TUSE_NONE = 2'd3.
  - The Tnew/Tuse encoding constants.
  - Default values for MULT_CYC and DIV_CYC.
- Sub-module md_busy_tracker contains md_cnt and its load/decrement logic. It is instantiated only under PIPE_HAZARD_MD_EN.

## Test plan
- Load-use:
  - Stimulus: lw in E (e_wa = 2, e_tnew = 2); addu in D (d_rs = 2, d_tuse_rs = 1).
  - Response: stall = 1, flush_e = 1.
  - Next cycle: lw in M (m_tnew = 1) → stall = 0.
- Register $0:
  - Stimulus: e_wa = 0, e_tnew = 2, d_rs = 0, d_tuse_rs = 0.
  - Response: stall = 0.
- Unused operand:
  - Stimulus: d_tuse_rt = 3 with d_rt == e_wa.
  - Response: stall = 0.
- Mult then mfhi:
  - Stimulus: e_md_start = 1, e_md_div = 0 at t; d_md = 1 held.
  - Response: stall high for t..t+5 (6 cycles); md_cnt reads 5, 4, 3, 2, 1, 0.
- Div then exception:
  - Stimulus: div start at t; intexc at t+3.
  - Response: at t+3, stall = 0, flush_e = 1, dclr = 1. md_cnt continues 7, 6, … and reaches 0 at t+11.
- Start suppressed by intexc:
  - Stimulus: e_md_start and intexc in the same cycle.
  - Response: md_cnt stays 0.
- Reset mid-divide:
  - Stimulus: reset during a div.
  - Response: md_cnt = 0 on the next edge.
- Delay-slot annul:
  - Stimulus: d_clr_req = 1 with a stall active.
  - Response: dclr = 0.
  - With no stall: dclr = 1.
